cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 25 ++
 rtl/cdb_arbiter_rr_pick4.sv | 25 ++
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
// Requester indices follow the physical port order: ALU, multiplier, divider, load/store.
package cdb_pkg;

   localparam int unsigned CDB_W  = 41;
   localparam int unsigned TAG_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WORD_W = TAG_W + DATA_W;

   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_MUL = 1;
   localparam int unsigned REQ_DIV = 2;
   localparam int unsigned REQ_LS  = 3;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] value;
   } cdb_word_t;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick4.sv
// Round-robin search over a 4-bit eligible mask, starting at ptr and moving upward mod 4.
// Purely combinational; the first eligible index found is the winner.
module rr_pick4 (
   input  logic [3:0] mask,
   input  logic [1:0] ptr,
   output logic [1:0] winner,
   output logic       found
);

   logic [1:0] cand;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         cand = ptr + 2'(k);
         if (!found && mask[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Four-way common data bus arbiter: round-robin with a starvation override,
// registered one-hot grant and broadcast word, plus a free-running broadcast counter.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned NUM_REQ      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        req,
   input  logic [WORD_W-1:0] alu_cdb_in,
   input  logic [WORD_W-1:0] mul_cdb_in,
   input  logic [WORD_W-1:0] div_cdb_in,
   input  logic [WORD_W-1:0] ls_cdb_in,
   output logic [CDB_W-1:0]  cdb,
   output logic [3:0]        grant,
   output logic [3:0]        starving,
   output logic [31:0]       bcast_count
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [WORD_W-1:0] data [NUM_REQ];
   logic [3:0]        wait_cnt [NUM_REQ];
   logic [3:0]        eligible;
   logic [1:0]        ptr;
   logic [1:0]        rr_idx;
   logic              rr_found;
   logic [1:0]        starve_idx;
   logic              starve_hit;
   logic [1:0]        win_idx;
   logic              win;
   cdb_word_t         cdb_q;
   logic [3:0]        grant_q;
   logic [31:0]       bcast_q;

   assign data[REQ_ALU] = alu_cdb_in;
   assign data[REQ_MUL] = mul_cdb_in;
   assign data[REQ_DIV] = div_cdb_in;
   assign data[REQ_LS]  = ls_cdb_in;

   // A requester sees its grant one cycle late, so its still-high req is masked for that cycle.
   assign eligible = req & ~grant_q;

   rr_pick4 u_pick (
      .mask   (eligible),
      .ptr    (ptr),
      .winner (rr_idx),
      .found  (rr_found)
   );

   always_comb begin
      starve_hit = 1'b0;
      starve_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!starve_hit && eligible[i] && wait_cnt[i] == LIMIT) begin
            starve_hit = 1'b1;
            starve_idx = 2'(i);
         end
      end
   end

   assign win     = starve_hit | rr_found;
   assign win_idx = starve_hit ? starve_idx : rr_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_q   <= '0;
         grant_q <= '0;
         ptr     <= '0;
         bcast_q <= '0;
      end else begin
         grant_q     <= '0;
         cdb_q.valid <= 1'b0;
         if (win) begin
            cdb_q   <= {1'b1, data[win_idx]};
            grant_q <= onehot4(win_idx);
            ptr     <= win_idx + 2'd1;
            bcast_q <= bcast_q + 32'd1;
         end
      end
   end

   // A masked requester (req high during its own grant cycle) holds its count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!req[i] || (win && win_idx == 2'(i)))
               wait_cnt[i] <= '0;
            else if (eligible[i] && wait_cnt[i] != LIMIT)
               wait_cnt[i] <= wait_cnt[i] + 4'd1;
         end
      end
   end

   always_comb begin
      starving = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) starving[i] = (wait_cnt[i] == LIMIT);
   end

   assign cdb         = cdb_q;
   assign grant       = grant_q;
   assign bcast_count = bcast_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized handshaking
// requesters, all compared against a behavioural model of the arbitration rules.
module tb_cdb_arbiter;

   localparam int LIMIT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [39:0] din [4];
   logic [40:0] cdb;
   logic [3:0]  grant;
   logic [3:0]  starving;
   logic [31:0] bcast_count;

   int checks   = 0;
   int failures = 0;

   // behavioural model state
   int          m_cnt [4];
   int          m_ptr;
   logic [3:0]  m_grant;
   logic [40:0] m_cdb;
   logic [31:0] m_count;

   always #5 clk = ~clk;

   cdb_arbiter #(.STARVE_LIMIT(LIMIT), .NUM_REQ(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .alu_cdb_in  (din[0]),
      .mul_cdb_in  (din[1]),
      .div_cdb_in  (din[2]),
      .ls_cdb_in   (din[3]),
      .cdb         (cdb),
      .grant       (grant),
      .starving    (starving),
      .bcast_count (bcast_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ptr   = 0;
      m_grant = '0;
      m_cdb   = '0;
      m_count = '0;
   endtask

   task automatic model_step();
      bit elig [4];
      int w;
      w = -1;
      for (int i = 0; i < 4; i++) elig[i] = req[i] && !m_grant[i];
      for (int i = 0; i < 4; i++)
         if (w < 0 && elig[i] && m_cnt[i] == LIMIT) w = i;
      for (int k = 0; k < 4; k++)
         if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      for (int i = 0; i < 4; i++) begin
         if (!req[i] || i == w) m_cnt[i] = 0;
         else if (elig[i] && m_cnt[i] < LIMIT) m_cnt[i] = m_cnt[i] + 1;
      end
      if (w >= 0) begin
         m_cdb   = {1'b1, din[w]};
         m_grant = 4'b0001 << w;
         m_ptr   = (w + 1) % 4;
         m_count = m_count + 32'd1;
      end else begin
         m_cdb[40] = 1'b0;
         m_grant   = '0;
      end
   endtask

   function automatic logic [3:0] model_starving();
      logic [3:0] s;
      for (int i = 0; i < 4; i++) s[i] = (m_cnt[i] == LIMIT);
      return s;
   endfunction

   task automatic compare_all(input string tag);
      check({tag, ".cdb"},      64'(cdb),         64'(m_cdb));
      check({tag, ".grant"},    64'(grant),       64'(m_grant));
      check({tag, ".starving"}, 64'(starving),    64'(model_starving()));
      check({tag, ".bcast"},    64'(bcast_count), 64'(m_count));
   endtask

   // one clock: model follows the edge, outputs sampled on the falling edge
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      model_reset();
      #1;
      compare_all("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [39:0] rand_word();
      return {8'($urandom), 32'($urandom)};
   endfunction

   initial begin
      logic [3:0] order [8];
      for (int i = 0; i < 4; i++) din[i] = '0;
      model_reset();
      #1;
      compare_all("por");
      do_reset();

      // single ALU request
      req = 4'b0001;
      din[0] = 40'h05_0000_002A;
      tick("single");
      check("single.cdb_const", 64'(cdb), 64'h1_05_0000_002A);
      check("single.grant_const", 64'(grant), 64'h1);
      req = '0;
      tick("single_after");
      check("single_after.valid", 64'(cdb[40]), 64'h0);

      // div holds req through its grant cycle: exactly one broadcast
      req = 4'b0100;
      din[2] = 40'hA7_1234_5678;
      tick("mask");
      check("mask.grant_const", 64'(grant), 64'h4);
      tick("mask_hold");
      check("mask_hold.grant_const", 64'(grant), 64'h0);
      check("mask_hold.valid", 64'(cdb[40]), 64'h0);
      req = '0;
      tick("mask_drop");

      // reset while a broadcast is on the bus
      req = 4'b0001;
      din[0] = rand_word();
      @(posedge clk);
      model_step();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("midrst.cdb", 64'(cdb), 64'h0);
      check("midrst.grant", 64'(grant), 64'h0);
      check("midrst.bcast", 64'(bcast_count), 64'h0);
      req = '0;
      @(negedge clk);
      rst = 1'b0;

      // starvation: index 3 skipped twice, then wins ahead of rr order
      req = 4'b1011;
      for (int i = 0; i < 4; i++) din[i] = rand_word();
      tick("starve1");
      check("starve1.grant_const", 64'(grant), 64'h1);
      req = 4'b1010;
      tick("starve2");
      check("starve2.grant_const", 64'(grant), 64'h2);
      check("starve2.starving3", 64'(starving[3]), 64'h1);
      req = 4'b1100;
      tick("starve3");
      check("starve3.grant_const", 64'(grant), 64'h8);
      req = 4'b0100;
      tick("starve4");
      check("starve4.starving3", 64'(starving[3]), 64'h0);
      req = '0;
      tick("starve5");

      // all four requesting continuously from reset
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         tick("all4");
         order[c] = grant;
         for (int i = 0; i < 4; i++) if (m_grant[i]) din[i] = rand_word();
      end
      for (int c = 0; c < 8; c++) check($sformatf("all4.order%0d", c), 64'(order[c]), 64'(4'b0001 << (c % 4)));
      check("all4.bcast_const", 64'(bcast_count), 64'd8);
      req = '0;
      tick("all4_drop");

      // randomized handshaking requesters
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (m_grant[i]) begin
               if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
               else begin
                  req[i] = 1'b1;
                  din[i] = rand_word();
               end
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               din[i] = rand_word();
            end
         end
         tick("rand");
      end
      req = '0;
      tick("rand_drop");

      // broadcast counter wrap
      force dut.bcast_q = 32'hFFFF_FFFF;
      #1;
      release dut.bcast_q;
      m_count = 32'hFFFF_FFFF;
      req = 4'b0010;
      din[1] = rand_word();
      tick("wrap");
      check("wrap.bcast_const", 64'(bcast_count), 64'h0);
      req = '0;
      tick("wrap_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
